// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: forwarding select codes and controller FSM states
package pipe_hazard_ctrl_pkg;
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MALU  = 2'b01;
    localparam logic [1:0] FWD_MDOUT = 2'b10;
    localparam logic [1:0] FWD_WR    = 2'b11;
    typedef enum logic {S_HOLD = 1'b0, S_RUN = 1'b1} state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// pipe_hazard_ctrl_fwd_sel: ALU operand bypass selector for one Ex source register
// Ports: i_use/i_src = Ex operand read flag and register; i_m_* = Mem producer;
//        i_w_* = Wr producer; o_fwd = bypass mux select (FWD_* codes)
module pipe_hazard_ctrl_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       i_use,
    input  logic [4:0] i_src,
    input  logic       i_m_regwr,
    input  logic       i_m_memtoreg,
    input  logic [4:0] i_m_rw,
    input  logic       i_w_regwe,
    input  logic [4:0] i_w_rw,
    output logic [1:0] o_fwd
);
    // Mem is checked before Wr so the youngest producer wins; $0 never forwards
    assign o_fwd = (!i_use || i_src == 5'd0)        ? FWD_REG :
                   (i_m_regwr && i_m_rw == i_src)   ? (i_m_memtoreg ? FWD_MDOUT : FWD_MALU) :
                   (i_w_regwe && i_w_rw == i_src)   ? FWD_WR : FWD_REG;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard, forwarding and flush control for the five-stage pipeline
// Ports: Clk/Rst = clock, sync active-high reset; Rs/Rt/UseRs/UseRt = ID sources;
//        E_*/M_*/W_* = downstream producer info; PCSrc = Mem redirect;
//        PC_WE/IF_ID_WE/*_Flush = pipeline register control; FwdA/FwdB = ALU bypass
//        selects; StallCnt/FlushCnt = saturating debug event counters
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       Rs,
    input  logic [4:0]       Rt,
    input  logic             UseRs,
    input  logic             UseRt,
    input  logic [4:0]       E_Rw,
    input  logic             E_RegWr,
    input  logic             E_MemtoReg,
    input  logic [4:0]       M_Rw,
    input  logic             M_RegWr,
    input  logic             M_MemtoReg,
    input  logic [4:0]       W_Rw,
    input  logic             W_RegWE,
    input  logic             PCSrc,
    output logic             PC_WE,
    output logic             IF_ID_WE,
    output logic             IF_ID_Flush,
    output logic             ID_Ex_Flush,
    output logic             Ex_Mem_Flush,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);
    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    state_t          r_state, w_state_nxt;
    logic [HC_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic [4:0]      r_e_rs, r_e_rt;
    logic            r_e_use_rs, r_e_use_rt;
    logic            w_hold, w_lu, w_stall_inc, w_flush_inc;
    logic [1:0]      w_fwd_a, w_fwd_b;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= HC_W'(HOLD_CYCLES - 1);
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        if (r_state == S_HOLD) begin
            if (r_hold_cnt == '0) w_state_nxt = S_RUN;
            else w_hold_cnt_nxt = r_hold_cnt - 1'b1;
        end
    end

    // Reset acts like HOLD in its own cycle so the pipeline is quiesced immediately
    assign w_hold = Rst || r_state == S_HOLD;
    assign w_lu   = E_MemtoReg && E_RegWr && E_Rw != 5'd0 &&
                    ((UseRs && Rs == E_Rw) || (UseRt && Rt == E_Rw));

    // A redirect squashes the stalled instruction anyway, so it overrides load-use
    assign PC_WE        = !w_hold && (PCSrc || !w_lu);
    assign IF_ID_WE     = PC_WE;
    assign IF_ID_Flush  = w_hold || PCSrc;
    assign ID_Ex_Flush  = w_hold || PCSrc || w_lu;
    assign Ex_Mem_Flush = w_hold || PCSrc;
    assign w_stall_inc  = !w_hold && !PCSrc && w_lu;
    assign w_flush_inc  = !w_hold && PCSrc;

    // Ex source tracking: a bubble carries no register reads
    always_ff @(posedge Clk) begin
        if (Rst || ID_Ex_Flush) begin
            r_e_rs     <= '0;
            r_e_rt     <= '0;
            r_e_use_rs <= 1'b0;
            r_e_use_rt <= 1'b0;
        end else begin
            r_e_rs     <= Rs;
            r_e_rt     <= Rt;
            r_e_use_rs <= UseRs;
            r_e_use_rt <= UseRt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (w_stall_inc && StallCnt != '1) StallCnt <= StallCnt + 1'b1;
            if (w_flush_inc && FlushCnt != '1) FlushCnt <= FlushCnt + 1'b1;
        end
    end

    pipe_hazard_ctrl_fwd_sel u_fwd_a (
        .i_use(r_e_use_rs), .i_src(r_e_rs),
        .i_m_regwr(M_RegWr), .i_m_memtoreg(M_MemtoReg), .i_m_rw(M_Rw),
        .i_w_regwe(W_RegWE), .i_w_rw(W_Rw), .o_fwd(w_fwd_a)
    );

    pipe_hazard_ctrl_fwd_sel u_fwd_b (
        .i_use(r_e_use_rt), .i_src(r_e_rt),
        .i_m_regwr(M_RegWr), .i_m_memtoreg(M_MemtoReg), .i_m_rw(M_Rw),
        .i_w_regwe(W_RegWE), .i_w_rw(W_Rw), .o_fwd(w_fwd_b)
    );

    assign FwdA = Rst ? FWD_REG : w_fwd_a;
    assign FwdB = Rst ? FWD_REG : w_fwd_b;
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard, forwarding and flush controller for the five-stage pipelined CPU (IF, ID, Ex, Mem, Wr).
- Tracks the source registers of the instruction in Ex.
- Selects forwarding sources for both ALU operands.
- Inserts one bubble on a load-use dependence.
- Squashes the three younger stages when Mem redirects the PC.
- Holds the PC for a fixed number of cycles after reset.
- Keeps saturating stall and flush counters for debug.

## Interface
Parameters:
- HOLD_CYCLES, 2, cycles PC/IF_ID stay frozen after reset release (≥1)
- CNT_W, 16, width of stall/flush event counters

Ports (clock and reset: one clock; reset is synchronous and active-high):
- Clk  in  1  pipeline clock, rising edge
- Rst  in  1  synchronous, active-high reset
- Rs, Rt  in  5 each  ID-stage source register fields
- UseRs, UseRt  in  1 each  ID instruction reads Rs / Rt
- E_Rw  in  5  Ex destination register
- E_RegWr, E_MemtoReg  in  1 each  Ex writes reg / is load
- M_Rw  in  5  Mem destination register
- M_RegWr, M_MemtoReg  in  1 each  Mem writes reg / is load
- W_Rw  in  5  Wr destination register
- W_RegWE  in  1  Wr write enable (already overflow-gated)
- PCSrc  in  1  Mem-stage redirect (jump or taken branch)
- PC_WE  out  1  PC load enable
- IF_ID_WE  out  1  IF_ID load enable
- IF_ID_Flush, ID_Ex_Flush, Ex_Mem_Flush  out  1 each  load bubble (all controls 0) at next edge
- FwdA, FwdB  out  2  Ex ALU operand source: 00 regfile bus, 01 M_ALUout, 10 M_Dout, 11 W_RegDin
- StallCnt, FlushCnt  out  CNT_W  saturating event counters

## Operation
- FSM states: HOLD, RUN.
  - Rst=1 → HOLD, hold counter = HOLD_CYCLES-1.
  - HOLD: PC_WE=0, IF_ID_WE=0, all three flushes=1. Decrement each cycle; at 0 → RUN.
- Ex tracking registers (E_Rs, E_Rt, E_UseRs, E_UseRt):
  - Load from ID on every edge where ID_Ex is not flushed.
  - Clear to 0 on flush, Rst, or HOLD.
- Load-use hazard (RUN), LU:
  - Requires E_MemtoReg & E_RegWr & E_Rw≠0.
  - And either (UseRs & Rs==E_Rw) or (UseRt & Rt==E_Rw).
  - LU gives PC_WE=0, IF_ID_WE=0, ID_Ex_Flush=1. StallCnt+1.
- Redirect (RUN, PCSrc=1):
  - PC_WE=1, IF_ID_WE=1.
  - IF_ID_Flush=ID_Ex_Flush=Ex_Mem_Flush=1. FlushCnt+1.
  - Takes priority over LU: LU is ignored that cycle and StallCnt is not incremented.
- Otherwise (RUN, no LU, no PCSrc): PC_WE=IF_ID_WE=1, all flushes 0.
- Forwarding for FwdA (E_Rs/E_UseRs); FwdB is identical using E_Rt/E_UseRt:
  - No forwarding (00) if E_UseRs=0 or E_Rs=0.
  - Else if M_RegWr & M_Rw==E_Rs: 10 if M_MemtoReg, else 01.
  - Else if W_RegWE & W_Rw==E_Rs: 11.
  - Else 00.
  - Mem source has priority over Wr source (youngest producer wins).
- Register 0 never forwards and never causes a stall.
- Counters:
  - Saturate at all-ones.
  - Clear on Rst.
  - Never increment in HOLD.

## Timing
- All control outputs are combinational from the current inputs, the FSM state and the Ex tracking registers; they act at the next rising Clk.
- Reset values (Rst=1 in the cycle):
  - PC_WE=0, IF_ID_WE=0.
  - All flushes=1.
  - FwdA=FwdB=00.
  - Counters 0.
- Load-use costs exactly 1 bubble. The cycle after the stall, the load is in Mem and the dependent instruction's operand forwards with code 10 (M_Dout).
- Redirect cost: 3 squashed instructions. The new PC is fetched in the cycle after PCSrc.
- Rst asserted mid-stall or mid-redirect: Rst wins; next state HOLD regardless.
- Back-to-back LU is impossible: the bubble has E_MemtoReg=0.

## Structure
- Shared package/header holds:
  - FWD_REG=2'b00, FWD_MALU=2'b01, FWD_MDOUT=2'b10, FWD_WR=2'b11
  - state encodings S_HOLD, S_RUN
- Natural sub-module: fwd_sel, the pure combinational forwarding selector, instantiated twice (operand A and operand B).
- Top-level wiring change: the bypass mux in front of the ALU X input and the mux in front of AluB's X0 input take FwdA and FwdB respectively.

## Test plan
- Reset with HOLD_CYCLES=2: Rst high 1 cycle, then low → PC_WE=0 for 2 cycles, 1 from cycle 3; flushes 1 during HOLD; counters 0.
- lw $1,0($0) followed by add $2,$1,$3 → exactly one cycle with PC_WE=0 and ID_Ex_Flush=1; next cycle FwdA=10; StallCnt=1.
- add $1 then sub $4,$1,$1 → FwdA=FwdB=01, no stall. Repeat with one nop between → FwdA=FwdB=11.
- Producer writes $0 (E_Rw=0, load) with Rs=0 → no stall, FwdA=00.
- PCSrc=1 in the same cycle as an LU condition → three flushes=1, PC_WE=1, FlushCnt+1, StallCnt unchanged.
- Force 2^CNT_W+3 redirects (CNT_W=4 build: 19) → FlushCnt saturates at 15. Rst mid-run → FlushCnt=0 and HOLD re-entered.
